// File: rtl/score_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : score_ram_writer
// Description : Write-port sequencer for a (N+1)x(N+1) row-major score RAM.
//               On init_start it writes the gap-penalty border (row 0, then
//               column 0) as 2N+1 back-to-back writes, then enters RUN where
//               each en_write stores score_in into cell (i+1, j+1) one cycle
//               later.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               init_start - start/restart border initialisation
//               en_write   - cell write request (qualifies i, j, score_in)
//               i, j       - cell indices, written to (i+1, j+1)
//               score_in   - signed cell score
//               we         - registered RAM write strobe
//               addr       - registered RAM write address
//               data_out   - registered RAM write data
//               busy       - border initialisation in progress
//               init_done  - border written, accepting cell writes
//               err        - one-cycle pulse on a rejected (out-of-range) write
// Options     : SCORE_WR_RANGE_CHK_EN - when defined, writes with i>=N or
//               j>=N are dropped and flagged on err; otherwise err is tied 0
//               and the address simply wraps to ADDR_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module score_ram_writer #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int ADDR_W  = $clog2((N + 1) * (N + 1)),
  parameter int SCORE_W = 10,
  parameter int GAP     = -2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_start,
  input  logic                      en_write,
  input  logic [BitAddr:0]          i,
  input  logic [BitAddr:0]          j,
  input  logic signed [SCORE_W-1:0] score_in,
  output logic                      we,
  output logic [ADDR_W-1:0]         addr,
  output logic signed [SCORE_W-1:0] data_out,
  output logic                      busy,
  output logic                      init_done,
  output logic                      err
);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_init_row = 2'd1;
  localparam logic [1:0] c_st_init_col = 2'd2;
  localparam logic [1:0] c_st_run      = 2'd3;

  localparam logic signed [SCORE_W-1:0] c_gap       = SCORE_W'(GAP);
  localparam logic [ADDR_W-1:0]         c_stride    = ADDR_W'(N + 1);
  localparam logic [31:0]               c_stride_32 = 32'(N + 1);
  localparam logic [BitAddr:0]          c_k_last    = (BitAddr + 1)'(N);
  localparam logic [BitAddr:0]          c_k_one     = (BitAddr + 1)'(1);

  logic [1:0]                r_state;
  logic [BitAddr:0]          r_k;
  logic                      r_we;
  logic [ADDR_W-1:0]         r_addr;
  // r_data doubles as the running border value v during initialisation.
  logic signed [SCORE_W-1:0] r_data;

  logic              w_start;
  logic              w_run_write;
  logic [ADDR_W-1:0] w_cell_addr;

  // init_start is honoured only from IDLE or RUN, and beats en_write in RUN.
  assign w_start     = init_start && ((r_state == c_st_idle) || (r_state == c_st_run));
  assign w_run_write = en_write && (r_state == c_st_run) && !init_start;

  // Computed at 32 bits, then wrapped to the RAM address width.
  assign w_cell_addr = ADDR_W'((32'(j) + 32'd1) + c_stride_32 * (32'(i) + 32'd1));

`ifdef SCORE_WR_RANGE_CHK_EN
  logic w_out_of_range;
  logic r_err;

  assign w_out_of_range = (32'(i) >= 32'(N)) || (32'(j) >= 32'(N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_run_write && w_out_of_range;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_k     <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_start) begin
      // First border write (cell 0, value 0) is presented on entry.
      r_state <= c_st_init_row;
      r_k     <= '0;
      r_we    <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        c_st_init_row: begin
          r_we <= 1'b1;
          if (r_k == c_k_last) begin
            // Column 0 starts at row 1; cell 0 was already written.
            r_state <= c_st_init_col;
            r_k     <= c_k_one;
            r_addr  <= c_stride;
            r_data  <= c_gap;
          end else begin
            r_k    <= r_k + c_k_one;
            r_addr <= r_addr + ADDR_W'(1);
            r_data <= r_data + c_gap;
          end
        end
        c_st_init_col: begin
          if (r_k == c_k_last) begin
            r_state <= c_st_run;
            r_we    <= 1'b0;
          end else begin
            r_we   <= 1'b1;
            r_k    <= r_k + c_k_one;
            r_addr <= r_addr + c_stride;
            r_data <= r_data + c_gap;
          end
        end
        c_st_run: begin
          r_we <= 1'b0;
          if (w_run_write) begin
`ifdef SCORE_WR_RANGE_CHK_EN
            if (!w_out_of_range) begin
              r_we   <= 1'b1;
              r_addr <= w_cell_addr;
              r_data <= score_in;
            end
`else
            r_we   <= 1'b1;
            r_addr <= w_cell_addr;
            r_data <= score_in;
`endif
          end
        end
        default: begin
          r_we <= 1'b0;
        end
      endcase
    end
  end

  assign we        = r_we;
  assign addr      = r_addr;
  assign data_out  = r_data;
  assign busy      = (r_state == c_st_init_row) || (r_state == c_st_init_col);
  assign init_done = (r_state == c_st_run);

endmodule
`default_nettype wire

// File: tb/tb_score_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_ram_writer
// Description : Directed self-checking bench for score_ram_writer with
//               N=4, GAP=-2, SCORE_W=10. Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_ram_writer;

  localparam int N       = 4;
  localparam int BitAddr = $clog2(N + 1);
  localparam int ADDR_W  = $clog2((N + 1) * (N + 1));
  localparam int SCORE_W = 10;

  logic                      clk;
  logic                      rst;
  logic                      init_start;
  logic                      en_write;
  logic [BitAddr:0]          i;
  logic [BitAddr:0]          j;
  logic signed [SCORE_W-1:0] score_in;
  logic                      we;
  logic [ADDR_W-1:0]         addr;
  logic signed [SCORE_W-1:0] data_out;
  logic                      busy;
  logic                      init_done;
  logic                      err;

  int n_checks = 0;
  int n_errors = 0;

  score_ram_writer #(
    .N       (N),
    .SCORE_W (SCORE_W),
    .GAP     (-2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .en_write   (en_write),
    .i          (i),
    .j          (j),
    .score_in   (score_in),
    .we         (we),
    .addr       (addr),
    .data_out   (data_out),
    .busy       (busy),
    .init_done  (init_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_addr [9] = '{0, 1, 2, 3, 4, 5, 10, 15, 20};
  int exp_data [9] = '{0, -2, -4, -6, -8, -2, -4, -6, -8};

  initial begin
    rst        = 1'b0;
    init_start = 1'b0;
    en_write   = 1'b0;
    i          = '0;
    j          = '0;
    score_in   = '0;

    step();
    step();
    check("rst_we",        int'(we),                0);
    check("rst_addr",      int'(addr),              0);
    check("rst_data",      int'($signed(data_out)), 0);
    check("rst_busy",      int'(busy),              0);
    check("rst_init_done", int'(init_done),         0);
    check("rst_err",       int'(err),               0);
    rst = 1'b1;

    // en_write in IDLE is ignored
    en_write = 1'b1; i = 0; j = 0; score_in = 10'sd9;
    step();
    en_write = 1'b0;
    check("idle_wr_we",  int'(we),   0);
    check("idle_wr_err", int'(err),  0);
    check("idle_busy",   int'(busy), 0);

    // Border initialisation; stray requests injected during INIT_COL
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int n = 0; n < 9; n++) begin
      check($sformatf("init_we_%0d", n),   int'(we),                1);
      check($sformatf("init_addr_%0d", n), int'(addr),              exp_addr[n]);
      check($sformatf("init_data_%0d", n), int'($signed(data_out)), exp_data[n]);
      check($sformatf("init_busy_%0d", n), int'(busy),              1);
      check($sformatf("init_done_%0d", n), int'(init_done),         0);
      if (n == 5) begin
        en_write = 1'b1; init_start = 1'b1; i = 0; j = 0; score_in = 10'sd7;
      end else begin
        en_write = 1'b0; init_start = 1'b0;
      end
      step();
    end
    en_write = 1'b0; init_start = 1'b0;
    check("post_init_we",   int'(we),        0);
    check("post_init_busy", int'(busy),      0);
    check("post_init_done", int'(init_done), 1);

    // Back-to-back cell writes
    en_write = 1'b1; i = 0; j = 0; score_in = 10'sd3;
    step();
    i = 3; j = 3; score_in = -10'sd5;
    check("wr0_we",   int'(we),                1);
    check("wr0_addr", int'(addr),              6);
    check("wr0_data", int'($signed(data_out)), 3);
    step();
    en_write = 1'b0;
    check("wr1_we",   int'(we),                1);
    check("wr1_addr", int'(addr),              24);
    check("wr1_data", int'($signed(data_out)), -5);
    step();
    check("hold_we",   int'(we),                0);
    check("hold_addr", int'(addr),              24);
    check("hold_data", int'($signed(data_out)), -5);

    // Out-of-range row index
    en_write = 1'b1; i = 4; j = 0; score_in = 10'sd7;
    step();
    en_write = 1'b0;
`ifdef SCORE_WR_RANGE_CHK_EN
    check("oor_we",   int'(we),   0);
    check("oor_err",  int'(err),  1);
    check("oor_addr", int'(addr), 24);
    step();
    check("oor_err_clr", int'(err), 0);
`else
    check("oor_we",   int'(we),                1);
    check("oor_addr", int'(addr),              26);
    check("oor_data", int'($signed(data_out)), 7);
    check("oor_err",  int'(err),               0);
`endif

    // init_start beats en_write in RUN
    init_start = 1'b1; en_write = 1'b1; i = 1; j = 1; score_in = 10'sd11;
    step();
    init_start = 1'b0; en_write = 1'b0;
    check("restart_busy", int'(busy),                1);
    check("restart_done", int'(init_done),           0);
    check("restart_we",   int'(we),                  1);
    check("restart_addr", int'(addr),                0);
    check("restart_data", int'($signed(data_out)),   0);
    step();
    check("restart2_addr", int'(addr), 1);
    step();
    check("restart3_addr", int'(addr),                2);
    check("restart3_data", int'($signed(data_out)),   -4);

    // Asynchronous reset during the third row write
    #2;
    rst = 1'b0;
    #1;
    check("arst_we",   int'(we),                0);
    check("arst_addr", int'(addr),              0);
    check("arst_data", int'($signed(data_out)), 0);
    check("arst_busy", int'(busy),              0);
    check("arst_done", int'(init_done),         0);
    step();
    rst = 1'b1;

    en_write = 1'b1; i = 1; j = 1; score_in = 10'sd11;
    step();
    en_write = 1'b0;
    check("post_rst_wr_we",  int'(we),  0);
    check("post_rst_wr_err", int'(err), 0);
    step();
    check("post_rst_busy", int'(busy),      0);
    check("post_rst_done", int'(init_done), 0);
    check("post_rst_we",   int'(we),        0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_ram_writer.md
SCORE_RAM_WRITER -- requirements
Module: score_ram_writer

Interface
REQ-001 Parameter N, default 128: sequence length; score matrix is (N+1)x(N+1), row-major, address = col + (N+1)*row.
REQ-002 Parameter BitAddr, default $clog2(N+1): i/j ports are BitAddr+1 bits wide.
REQ-003 Parameter ADDR_W, default $clog2((N+1)*(N+1)): address width.
REQ-004 Parameter SCORE_W, default 10: two's-complement score width.
REQ-005 Parameter GAP, default -2: signed gap penalty used for matrix border initialisation.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 init_start  input  1  one-cycle request to (re)initialise row 0 and column 0.
REQ-009 en_write  input  1  one-cycle request to write score_in to cell (i+1, j+1).
REQ-010 i, j  input  BitAddr+1 each  cell indices qualified by en_write.
REQ-011 score_in  input  SCORE_W signed  score qualified by en_write.
REQ-012 we  output  1  RAM write strobe, registered.
REQ-013 addr  output  ADDR_W  RAM write address, registered.
REQ-014 data_out  output  SCORE_W signed  RAM write data, registered.
REQ-015 busy  output  1  high while in INIT_ROW or INIT_COL.
REQ-016 init_done  output  1  level, high while in RUN.
REQ-017 err  output  1  one-cycle pulse on a rejected write (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, INIT_ROW, INIT_COL, RUN.
REQ-019 IDLE or RUN with init_start=1 -> INIT_ROW next cycle, counter k=0, border value v=0.
REQ-020 INIT_ROW: each cycle we=1, addr=k, data_out=v; then k+1, v+GAP; after k=N -> INIT_COL with k=1, v=GAP.
REQ-021 INIT_COL: each cycle we=1, addr=k*(N+1), data_out=v; address advanced by adding N+1 (no multiplier); after k=N -> RUN.
REQ-022 Initialisation SHALL issue exactly 2N+1 consecutive writes with no gaps; init_done rises the cycle after the last write.
REQ-023 v SHALL be accumulated by adding sign-extended GAP each step and truncated to SCORE_W.
REQ-024 RUN with en_write=1: next cycle we=1, addr=(j+1)+(N+1)*(i+1), data_out=score_in; latency 1 cycle; back-to-back en_write SHALL produce back-to-back writes.
REQ-025 en_write in IDLE, INIT_ROW or INIT_COL SHALL be ignored (no we, no err).
REQ-026 init_start and en_write together in RUN: init_start wins; the write is dropped.
REQ-027 init_start during INIT_ROW/INIT_COL SHALL be ignored.
REQ-028 When we=0, addr and data_out SHALL hold their last values.

Reset
REQ-029 rst low SHALL immediately force state IDLE, we=0, addr=0, data_out=0, busy=0, init_done=0, err=0, k=0, v=0.
REQ-030 Reset mid-initialisation SHALL abort it; a new init_start is required afterwards.

Configuration
REQ-031 Macro SCORE_WR_RANGE_CHK_EN defined: en_write in RUN with i>=N or j>=N SHALL produce no write and err=1 for one cycle.
REQ-032 Macro SCORE_WR_RANGE_CHK_EN undefined: range check absent, err tied 0, write issued with address truncated to ADDR_W.

Verification (N=4, GAP=-2, SCORE_W=10)
REQ-033 init_start pulse -> 9 consecutive writes: addr 0,1,2,3,4 data 0,-2,-4,-6,-8; then addr 5,10,15,20 data -2,-4,-6,-8; busy high for those 9 cycles; init_done high next cycle.
REQ-034 RUN, en_write i=0 j=0 score_in=3 -> next cycle we=1 addr=6 data_out=3; then i=3 j=3 score_in=-5 -> addr=24 data_out=-5.
REQ-035 RUN, en_write i=4 j=0 -> with macro: we=0, err=1 one cycle; without macro: we=1 addr=26.
REQ-036 rst low during 3rd INIT_ROW write -> we=0 same cycle, outputs zero, state IDLE; en_write afterwards produces no write.
REQ-037 en_write during INIT_COL -> no extra write, sequence unchanged; init_start with en_write in RUN -> INIT_ROW entered, no cell write.
